tdm_mult_engine: RTL

- Parametrised successor to the fixed two-input round-robin TDM multiplier.
- Serves NUM_CH independent channels with valid/ready input handshakes.
- A work-conserving round-robin arbiter grants one pending channel per cycle. The granted sample is multiplied by that channel's own coefficient counter in a registered DSP-style pipeline.
- Tagged results pass through an output FIFO with valid/ready backpressure toward the pin/serializer stage.

---
 rtl/tdm_mult_engine_pkg.sv | 44 ++++
 rtl/tdm_mult_engine_if.sv | 22 ++
 rtl/tdm_mult_engine_arb.sv | 27 ++
 rtl/tdm_mult_engine.sv | 134 +++++++++++++
 4 files changed

// File: rtl/tdm_mult_engine_pkg.sv
// rtl/tdm_mult_engine_pkg.sv - shared types, default widths and round-robin helper for the TDM multiplier
// Package tdm_pkg: default parameter values, channel index / pipeline stage types,
// and rr_next(), the rotating first-set search used by the grant arbiter.
package tdm_pkg;

  localparam int NUM_CH_DEF     = 4;
  localparam int DATA_W_DEF     = 8;
  localparam int COEF_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int PROD_W_DEF     = DATA_W_DEF + COEF_W_DEF;

  // rr_next works on a fixed 16-wide request vector so one function serves every NUM_CH.
  localparam int MAX_CH    = 16;
  localparam int MAX_IDX_W = 4;

  typedef logic [$clog2(NUM_CH_DEF)-1:0] ch_idx_t;

  typedef struct packed {
    logic                  valid;
    ch_idx_t               ch;
    logic [DATA_W_DEF-1:0] a;
    logic [COEF_W_DEF-1:0] b;
    logic [PROD_W_DEF-1:0] m;
  } pipe_stage_t;

  // Returns {found, index} of the first set req bit at or after ptr, wrapping at n.
  // Scanned from the far end so the entry closest to ptr is the last (winning) write.
  function automatic logic [MAX_IDX_W:0] rr_next(input logic [MAX_IDX_W-1:0] ptr,
                                                 input logic [MAX_CH-1:0]    req,
                                                 input int                   n);
    logic [MAX_IDX_W:0] res;
    int                 idx;
    res = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) res = {1'b1, MAX_IDX_W'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tdm_mult_engine_if.sv
// rtl/tdm_mult_engine_if.sv - channel input and tagged result stream interface
// Signals: din/din_valid/din_ready (per-channel sample handshakes),
//          dout/dout_ch/dout_valid/dout_ready (result stream).
// master: traffic source and result sink; slave: the engine.
interface tdm_mult_engine_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
);
  logic [NUM_CH*DATA_W-1:0]     din;
  logic [NUM_CH-1:0]            din_valid;
  logic [NUM_CH-1:0]            din_ready;
  logic [DATA_W+COEF_W-1:0]     dout;
  logic [$clog2(NUM_CH)-1:0]    dout_ch;
  logic                         dout_valid;
  logic                         dout_ready;

  modport master (output din, din_valid, dout_ready,
                  input  din_ready, dout, dout_ch, dout_valid);
  modport slave  (input  din, din_valid, dout_ready,
                  output din_ready, dout, dout_ch, dout_valid);
endinterface

// File: rtl/tdm_mult_engine_arb.sv
// rtl/tdm_mult_engine_arb.sv - combinational work-conserving round-robin grant
// Ports: req_i (pending channels), enable_i (issue credit available), ptr_i (scan start),
//        grant_o (one-hot), grant_idx_o (binary index), grant_v_o (a grant was issued).
module rr_grant_arbiter
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic                      enable_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  output logic [NUM_CH-1:0]         grant_o,
  output logic [$clog2(NUM_CH)-1:0] grant_idx_o,
  output logic                      grant_v_o
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [MAX_IDX_W:0] pick;

  always_comb begin
    pick        = rr_next(MAX_IDX_W'(ptr_i), MAX_CH'(req_i), NUM_CH);
    grant_v_o   = enable_i & pick[MAX_IDX_W];
    grant_idx_o = CH_W'(pick[MAX_IDX_W-1:0]);
    grant_o     = '0;
    if (grant_v_o) grant_o[grant_idx_o] = 1'b1;
  end
endmodule

// File: rtl/tdm_mult_engine.sv
// rtl/tdm_mult_engine.sv - round-robin TDM multiplier with per-channel coefficients and output FIFO
// Ports: clk, rst (sync, active-high), bus (tdm_mult_engine_if.slave).
// Build option TDM_MULT_ACCUM_EN: emit per-channel running sums instead of raw products.
module tdm_mult_engine
  import tdm_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int COEF_W     = COEF_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  tdm_mult_engine_if.slave   bus
);
  localparam int PW   = DATA_W + COEF_W;
  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  typedef struct packed {
    logic              valid;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] a;
    logic [COEF_W-1:0] b;
  } s1_t;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
    logic [PW-1:0]   m;
  } s2_t;

  logic [NUM_CH-1:0] hold_v_q, hold_v_d;
  logic [DATA_W-1:0] hold_q [NUM_CH];
  logic [COEF_W-1:0] coef_q [NUM_CH];
  logic [CH_W-1:0]   ptr_q, ptr_d;
  s1_t               s1_q;
  s2_t               s2_q;

  logic [PW-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [CH_W-1:0]   fifo_ch_q   [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic [NUM_CH-1:0] grant, accept;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_v, issue_ok, push, pop;
  logic [CW-1:0]     inflight;
  logic [PW-1:0]     s3_data;

  // Credit check counts results still in S1/S2 so the FIFO can never be overrun;
  // a pop in the same cycle is deliberately not credited.
  assign inflight = CW'(s1_q.valid) + CW'(s2_q.valid);
  assign issue_ok = (count_q + inflight) < CW'(FIFO_DEPTH);

  rr_grant_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i       (hold_v_q),
    .enable_i    (issue_ok),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_v_o   (grant_v)
  );

  // A granted hold register may be refilled in the same cycle it drains.
  assign bus.din_ready = ~hold_v_q | grant;
  assign accept        = bus.din_valid & bus.din_ready;
  assign hold_v_d      = (hold_v_q & ~grant) | accept;
  assign ptr_d         = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

  assign push           = s2_q.valid;
  assign bus.dout_valid = (count_q != '0);
  assign pop            = bus.dout_valid & bus.dout_ready;
  assign bus.dout       = bus.dout_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.dout_ch    = bus.dout_valid ? fifo_ch_q[rd_ptr_q]   : '0;

`ifdef TDM_MULT_ACCUM_EN
  logic [PW-1:0] acc_q [NUM_CH];

  assign s3_data = acc_q[s2_q.ch] + s2_q.m;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else if (s2_q.valid) begin
      acc_q[s2_q.ch] <= s3_data;
    end
  end
`else
  assign s3_data = s2_q.m;
`endif

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= '0;
      ptr_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) coef_q[i] <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      if (grant_v) ptr_q <= ptr_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant[i]) coef_q[i] <= coef_q[i] + 1'b1;
      end
      s1_q.valid <= grant_v;
      s1_q.ch    <= grant_idx;
      s1_q.a     <= hold_q[grant_idx];
      s1_q.b     <= coef_q[grant_idx];
      s2_q.valid <= s1_q.valid;
      s2_q.ch    <= s1_q.ch;
      s2_q.m     <= PW'(s1_q.a) * PW'(s1_q.b);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Datapath storage; contents are qualified by hold_v_q / count_q so need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept[i]) hold_q[i] <= bus.din[i*DATA_W +: DATA_W];
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= s3_data;
      fifo_ch_q[wr_ptr_q]   <= s2_q.ch;
    end
  end
endmodule
